stream_frame_capture: RTL and testbench
=======================================

// Module: stream_frame_capture
// PURPOSE
//  Receive end of the pixel stream interface (vsync/href/data) used to feed CNN_net.
//  Captures one IMG_W x IMG_H frame into an internal RAM and checks line/frame geometry.
//  Exposes a registered random-access read port for the downstream/readback logic.
//  Sits at the output of any stream producer (sensor bridge, CNN stage) for capture/checking.
// PARAMETERS
//  IMG_W   64   pixels per line
//  IMG_H   64   lines per frame
//  DATA_W  8    pixel width
//  ADDR_W  12   RAM address width; IMG_W*IMG_H <= 2**ADDR_W
//  ROW_W   7    width of row counter/report; IMG_H+1 < 2**ROW_W
// PORTS
//  clk         in   1       clock, all logic on rising edge
//  rst_n       in   1       reset, synchronous, active-low
//  in_vsync    in   1       frame-valid level; high for the whole frame
//  in_href     in   1       line-valid; one pixel per cycle while high
//  in_data     in   DATA_W  pixel, sampled when in_vsync & in_href
//  rd_addr     in   ADDR_W  read address (row*IMG_W+col)
//  rd_en       in   1       read strobe
//  rd_data     out  DATA_W  RAM data, 1-cycle latency after rd_en
//  busy        out  1       capture in progress (state LINE_WAIT/IN_LINE)
//  frame_done  out  1       1-cycle pulse at end of frame
//  frame_ok    out  1       valid with frame_done/holds till next frame start
//  line_err    out  1       sticky for current frame: some line length != IMG_W
//  row_err     out  1       sticky for current frame: line count != IMG_H
//  rows_rcvd   out  ROW_W   lines seen in current/last frame (saturates at IMG_H+1)
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all outputs 0, counters 0, state ARM; RAM contents undefined.
//  Edge detect: vsync_r/href_r registered copies; rise/fall = 1-cycle compare.
//  States:
//   ARM       : wait for in_vsync==0 (never start mid-frame after reset) -> IDLE
//   IDLE      : vsync rise -> LINE_WAIT; clear line_err,row_err,rows_rcvd,frame_ok,col,row
//   LINE_WAIT : href=1 -> IN_LINE (that pixel is col 0, written); vsync fall -> DONE
//   IN_LINE   : each href=1 cycle writes pixel, col++; href fall -> end-of-line, LINE_WAIT;
//               vsync fall while href=1 -> end-of-line then DONE
//   DONE      : 1 cycle; frame_done=1, frame_ok=!line_err&!row_err (final values) -> IDLE
//  Write: addr=row*IMG_W+col, only if col<IMG_W && row<IMG_H; else pixel dropped.
//  End-of-line: if col!=IMG_W set line_err; rows_rcvd++ (sat IMG_H+1); row++; col=0.
//  Short line: unwritten pixels keep old RAM content. Long line: extras dropped.
//  At DONE: row_err set if rows_rcvd!=IMG_H (incl. that cycle's update).
//  href with vsync=0: ignored, no write, no error.
//  Zero-length frame (vsync rise then fall, no href): frame_done, row_err=1, frame_ok=0.
//  rd_data: registered read, updates only when rd_en; same-addr read/write -> old data.
//  Reads allowed in any state; during capture return partially updated frame.
//  Reset mid-frame: back to ARM; no frame_done for aborted frame.
//  Latency: last pixel of frame -> frame_done is 2 cycles after vsync falls (edge reg + DONE).
// TESTING
//  1 64x64 frame, pixel=(row*64+col)&8'hFF, 20-cycle gaps -> one frame_done, frame_ok=1,
//    rows_rcvd=64, readback of all 4096 addresses matches, rd_data 1 cycle after rd_en.
//  2 Line 5 carries 63 pixels -> line_err=1, frame_ok=0, addr 5*64+63 keeps prior value.
//  3 Line 0 carries 70 pixels -> only 64 written, line 1 data at addr 64 correct,
//    line_err=1.
//  4 Frame of 63 lines -> row_err=1, rows_rcvd=63; next good frame clears errors,
//    frame_ok=1.
//  5 rst_n low mid-frame (line 30), released with vsync high -> no capture/frame_done until
//    vsync goes low then high; following full frame ok.
//  6 href pulses with vsync=0 and vsync fall during href -> ignored / line closed,
//    frame_done once.

Source files
------------

// File: rtl/stream_frame_capture.sv
// Frame capture for a vsync/href/data pixel stream: stores one IMG_W x IMG_H frame in RAM,
// checks the line and frame geometry, and provides a registered random-access read port.
module stream_frame_capture #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned ROW_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vsync,
  input  logic              in_href,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              line_err,
  output logic              row_err,
  output logic [ROW_W-1:0]  rows_rcvd
);

  localparam int unsigned COL_W = $clog2(IMG_W + 2);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {ARM, IDLE, LINE_WAIT, IN_LINE, DONE} state_t;

  state_t              state, state_n;
  logic                vsync_r, href_r;
  logic [COL_W-1:0]    col;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                vsync_rise_c, vsync_fall_c, href_fall_c;
  logic                pix_c, eol_c, clear_c, wr_en_c;
  logic [ADDR_W-1:0]   wr_addr_c;

  assign vsync_rise_c = in_vsync & ~vsync_r;
  assign vsync_fall_c = ~in_vsync & vsync_r;
  assign href_fall_c  = ~in_href & href_r;

  // rows_rcvd doubles as the current write row: both clear together and advance on every line end
  assign wr_en_c   = pix_c && (col < COL_W'(IMG_W)) && (rows_rcvd < ROW_W'(IMG_H));
  assign wr_addr_c = ADDR_W'(ADDR_W'(rows_rcvd) * ADDR_W'(IMG_W)) + ADDR_W'(col);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ARM;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    pix_c   = 1'b0;
    eol_c   = 1'b0;
    clear_c = 1'b0;
    case (state)
      ARM:       if (!in_vsync) state_n = IDLE;
      IDLE: begin
        if (vsync_rise_c) begin
          clear_c = 1'b1;
          state_n = LINE_WAIT;
        end
      end
      LINE_WAIT: begin
        if (vsync_fall_c) begin
          state_n = DONE;
        end else if (in_vsync && in_href) begin
          pix_c   = 1'b1;
          state_n = IN_LINE;
        end
      end
      IN_LINE: begin
        // a vsync fall closes the open line before the frame ends
        if (vsync_fall_c) begin
          eol_c   = 1'b1;
          state_n = DONE;
        end else if (href_fall_c) begin
          eol_c   = 1'b1;
          state_n = LINE_WAIT;
        end else begin
          pix_c = in_vsync & in_href;
        end
      end
      DONE:      state_n = IDLE;
      default:   state_n = ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_r    <= 1'b0;
      href_r     <= 1'b0;
      col        <= '0;
      rows_rcvd  <= '0;
      line_err   <= 1'b0;
      row_err    <= 1'b0;
      frame_ok   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      vsync_r    <= in_vsync;
      href_r     <= in_href;
      frame_done <= (state == DONE);
      busy       <= (state_n == LINE_WAIT) || (state_n == IN_LINE);
      if (clear_c) begin
        col       <= '0;
        rows_rcvd <= '0;
        line_err  <= 1'b0;
        row_err   <= 1'b0;
        frame_ok  <= 1'b0;
      end
      // column saturates one past the line width so long lines stay flagged
      if (pix_c && (col != COL_W'(IMG_W + 1))) col <= col + COL_W'(1);
      if (eol_c) begin
        col <= '0;
        if (col != COL_W'(IMG_W)) line_err <= 1'b1;
        if (rows_rcvd != ROW_W'(IMG_H + 1)) rows_rcvd <= rows_rcvd + ROW_W'(1);
      end
      if (state == DONE) begin
        row_err  <= row_err | (rows_rcvd != ROW_W'(IMG_H));
        frame_ok <= ~line_err & ~row_err & (rows_rcvd == ROW_W'(IMG_H));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_addr_c] <= in_data;
  end

  // read-before-write: a same-address write lands after this read samples
  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_stream_frame_capture.sv
// Randomized frame-capture bench: drives frames of chosen line lengths and predicts
// flags and RAM contents from the list of line lengths and pixels sent.
module tb_stream_frame_capture;
  localparam int IMG_W = 64;
  localparam int IMG_H = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_vsync = 1'b0;
  logic       in_href = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic [11:0] rd_addr = 12'd0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       busy, frame_done, frame_ok, line_err, row_err;
  logic [6:0] rows_rcvd;

  stream_frame_capture dut (
    .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_href(in_href), .in_data(in_data),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .busy(busy),
    .frame_done(frame_done), .frame_ok(frame_ok), .line_err(line_err),
    .row_err(row_err), .rows_rcvd(rows_rcvd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] ref_mem [4096];
  bit         ref_vld [4096];
  int         line_lens [$];
  int         cyc = 0, done_cnt = 0, done_cyc = 0, fall_cyc = 0;
  logic       d_ok, d_lerr, d_rerr;
  logic [6:0] d_rows;

  // frame_done monitor, sampled just after each rising edge
  always @(posedge clk) begin
    cyc++;
    #1;
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      d_ok = frame_ok; d_lerr = line_err; d_rerr = row_err; d_rows = rows_rcvd;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame(input int gap);
    @(negedge clk);
    in_vsync = 1'b1;
    line_lens.delete();
    idle(gap);
  endtask

  task automatic drive_line(input int len, input bit pattern, input int gap,
                            input bit vs_close, input bit model_on);
    int row;
    row = line_lens.size();
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      in_href = 1'b1;
      in_data = pattern ? 8'(row * IMG_W + c) : 8'($urandom);
      if (model_on && row < IMG_H && c < IMG_W) begin
        ref_mem[row * IMG_W + c] = in_data;
        ref_vld[row * IMG_W + c] = 1'b1;
      end
    end
    line_lens.push_back(len);
    if (vs_close) begin
      @(negedge clk);
      in_vsync = 1'b0;
      fall_cyc = cyc;
      @(negedge clk);
      in_href = 1'b0;
    end else begin
      @(negedge clk);
      in_href = 1'b0;
      in_data = 8'd0;
      idle(gap - 1);
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    in_vsync = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic check_frame(input string tag, input int prev_done);
    int n, t, rows_exp;
    bit lerr, rerr;
    n = line_lens.size();
    lerr = 1'b0;
    foreach (line_lens[i]) if (line_lens[i] != IMG_W) lerr = 1'b1;
    rerr = (n != IMG_H);
    rows_exp = (n > IMG_H + 1) ? IMG_H + 1 : n;
    t = 0;
    while (done_cnt == prev_done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, 32'(done_cnt), 32'(prev_done + 1));
    check({tag, "_latency"}, 32'(done_cyc - fall_cyc), 32'd2);
    check({tag, "_line_err"}, 32'(d_lerr), 32'(lerr));
    check({tag, "_row_err"}, 32'(d_rerr), 32'(rerr));
    check({tag, "_rows"}, 32'(d_rows), 32'(rows_exp));
    check({tag, "_ok"}, 32'(d_ok), 32'(!lerr && !rerr));
    idle(4);
    check({tag, "_single_done"}, 32'(done_cnt), 32'(prev_done + 1));
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic read_one(input string tag, input int a);
    @(negedge clk);
    rd_en = 1'b1;
    rd_addr = 12'(a);
    @(negedge clk);
    rd_en = 1'b0;
    check(tag, 32'(rd_data), 32'(ref_mem[a]));
  endtask

  task automatic readback(input string tag);
    for (int a = 0; a <= 4096; a++) begin
      @(negedge clk);
      if (a > 0 && ref_vld[a - 1]) check(tag, 32'(rd_data), 32'(ref_mem[a - 1]));
      rd_en = (a < 4096);
      rd_addr = 12'(a);
    end
    rd_en = 1'b0;
  endtask

  task automatic good_frame(input bit pattern, input int gap);
    start_frame(gap);
    for (int r = 0; r < IMG_H; r++) drive_line(IMG_W, pattern, gap, 1'b0, 1'b1);
    end_frame();
  endtask

  initial begin
    int pd;
    logic [7:0] held;
    idle(3);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_ok", 32'(frame_ok), 32'd0);
    check("rst_line_err", 32'(line_err), 32'd0);
    check("rst_row_err", 32'(row_err), 32'd0);
    check("rst_rows", 32'(rows_rcvd), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // 1: full patterned frame with wide gaps, then complete readback
    pd = done_cnt;
    start_frame(20);
    check("t1_busy_mid", 32'(busy), 32'd1);
    for (int r = 0; r < IMG_H; r++) drive_line(IMG_W, 1'b1, 20, 1'b0, 1'b1);
    end_frame();
    check_frame("t1", pd);
    readback("t1_rd");
    read_one("t1_rd_one", 1234);
    held = rd_data;
    @(negedge clk);
    rd_addr = 12'd7;
    @(negedge clk);
    check("t1_rd_hold", 32'(rd_data), 32'(held));

    // 2: line 5 one pixel short
    pd = done_cnt;
    start_frame(3);
    for (int r = 0; r < IMG_H; r++) drive_line((r == 5) ? IMG_W - 1 : IMG_W, 1'b0, 3, 1'b0, 1'b1);
    end_frame();
    check_frame("t2", pd);
    read_one("t2_short_keep", 5 * IMG_W + 63);
    read_one("t2_short_col62", 5 * IMG_W + 62);

    // 3: line 0 long, extras dropped
    pd = done_cnt;
    start_frame(3);
    for (int r = 0; r < IMG_H; r++) drive_line((r == 0) ? 70 : IMG_W, 1'b0, 3, 1'b0, 1'b1);
    end_frame();
    check_frame("t3", pd);
    read_one("t3_col63", 63);
    read_one("t3_line1", 64);

    // 4: 63-line frame, then a good frame clears errors
    pd = done_cnt;
    start_frame(3);
    for (int r = 0; r < IMG_H - 1; r++) drive_line(IMG_W, 1'b0, 3, 1'b0, 1'b1);
    end_frame();
    check_frame("t4a", pd);
    pd = done_cnt;
    good_frame(1'b0, 3);
    check_frame("t4b", pd);

    // 5: reset inside line 30, released with vsync still high
    pd = done_cnt;
    start_frame(3);
    for (int r = 0; r < 30; r++) drive_line(IMG_W, 1'b0, 3, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_href = 1'b1;
      in_data = 8'($urandom);
      ref_mem[30 * IMG_W + c] = in_data;
      ref_vld[30 * IMG_W + c] = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    idle(3);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_rows", 32'(rows_rcvd), 32'd0);
    rst_n = 1'b1;
    in_href = 1'b0;
    idle(2);
    for (int r = 0; r < 5; r++) drive_line(IMG_W, 1'b0, 3, 1'b0, 1'b0);
    check("t5_no_capture_busy", 32'(busy), 32'd0);
    end_frame();
    idle(10);
    check("t5_no_done", 32'(done_cnt), 32'(pd));
    pd = done_cnt;
    good_frame(1'b0, 2);
    check_frame("t5", pd);

    // 6: href with vsync low is ignored; vsync falls during the last line
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_href = 1'b1;
      in_data = 8'($urandom);
      idle(4);
      in_href = 1'b0;
      idle(2);
    end
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_idle_no_done", 32'(done_cnt), 32'(pd + 1));
    pd = done_cnt;
    start_frame(3);
    for (int r = 0; r < IMG_H; r++) drive_line(IMG_W, 1'b0, 3, r == IMG_H - 1, 1'b1);
    check_frame("t6", pd);

    // zero-length frame
    pd = done_cnt;
    start_frame(4);
    end_frame();
    check_frame("t7_empty", pd);

    readback("final_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
